// File: rtl/puerto_serie_pkg.sv
// Shared definitions for the memory-mapped serial transmitter:
// register offsets, status bit positions and transmit FSM states.
package puerto_serie_pkg;

   localparam logic [15:0] OFS_DATOS  = 16'd0;
   localparam logic [15:0] OFS_ESTADO = 16'd1;

   localparam int BIT_VACIO    = 0;
   localparam int BIT_LLENO    = 1;
   localparam int BIT_OCUPADO  = 2;
   localparam int BIT_DESBORDE = 3;

   typedef enum logic [1:0] {
      REPOSO,
      INICIO,
      DATOS,
      PARADA
   } estado_t;

endpackage

// File: rtl/fifo_sincrona.sv
// Small synchronous show-ahead FIFO. A push while full is accepted when a
// pop happens on the same edge, so the queue never stalls a back-to-back feed.
module fifo_sincrona #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     Vacio,
   output logic                     Lleno,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] CNT_LLENO = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign Vacio   = (count == '0);
   assign Lleno   = (count == CNT_LLENO);
   assign pop_ok  = pop & ~Vacio;
   assign push_ok = push & (~Lleno | pop_ok);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array, left unreset since the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/puerto_serie_tx.sv
// Bus-attached 8N1 serial transmitter: address decode, status read mux,
// sticky overflow flag, byte FIFO and the transmit FSM with its bit timer.
module puerto_serie_tx
   import puerto_serie_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR    = 16'hFFF0,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        Reloj,
   input  logic        Reiniciar,
   input  logic [15:0] Direcciones,
   input  logic [15:0] DatosEntrada,
   output logic [15:0] DatosSalida,
   output logic        DatosOe,
   input  logic        oeM,
   input  logic        WR,
   output logic        Tx,
   output logic        Ocupado
);

   localparam int           CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int           TW    = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_FIN = TW'(CLKS_PER_BIT - 1);

   estado_t       estado;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    desplaz;
   logic          desborde;

   logic          hit_datos;
   logic          hit_estado;
   logic          esc_datos;
   logic          esc_estado;
   logic          lectura;
   logic          pop_tx;
   logic [7:0]    fifo_dout;
   logic          vacio;
   logic          lleno;
   logic [CW-1:0] fifo_count;
   logic [15:0]   estado_reg;
   logic          unused_bits;

   assign hit_datos  = (Direcciones == BASE_ADDR + OFS_DATOS);
   assign hit_estado = (Direcciones == BASE_ADDR + OFS_ESTADO);
   assign esc_datos  = oeM & WR & hit_datos;
   assign esc_estado = oeM & WR & hit_estado;
   assign lectura    = oeM & ~WR & (hit_datos | hit_estado);
   assign Ocupado    = (estado != REPOSO) | ~vacio;
   assign unused_bits = ^{fifo_count, DatosEntrada[15:8]};

   fifo_sincrona #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Reloj),
      .rst   (Reiniciar),
      .push  (esc_datos),
      .pop   (pop_tx),
      .din   (DatosEntrada[7:0]),
      .dout  (fifo_dout),
      .Vacio (vacio),
      .Lleno (lleno),
      .count (fifo_count)
   );

   // Pop a new byte when idle, or at the last stop-bit cycle to chain frames
   always_comb begin
      pop_tx = 1'b0;
      case (estado)
         REPOSO:  pop_tx = ~vacio;
         PARADA:  pop_tx = (timer == '0) & ~vacio;
         default: pop_tx = 1'b0;
      endcase
   end

   // Status word and bus read mux; data address reads back as zero
   always_comb begin
      estado_reg               = '0;
      estado_reg[BIT_VACIO]    = vacio;
      estado_reg[BIT_LLENO]    = lleno;
      estado_reg[BIT_OCUPADO]  = Ocupado;
      estado_reg[BIT_DESBORDE] = desborde;
      DatosOe     = lectura;
      DatosSalida = (lectura & hit_estado) ? estado_reg : 16'h0000;
   end

   // Sticky overflow: set on a dropped byte, cleared by a status write of bit 3
   always_ff @(posedge Reloj) begin
      if (Reiniciar) begin
         desborde <= 1'b0;
      end else if (esc_datos & lleno & ~pop_tx) begin
         desborde <= 1'b1;
      end else if (esc_estado & DatosEntrada[BIT_DESBORDE]) begin
         desborde <= 1'b0;
      end
   end

   // Transmit FSM: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT long
   always_ff @(posedge Reloj) begin
      if (Reiniciar) begin
         estado  <= REPOSO;
         timer   <= '0;
         bit_idx <= '0;
         Tx      <= 1'b1;
      end else begin
         case (estado)
            REPOSO: begin
               Tx <= 1'b1;
               if (!vacio) begin
                  desplaz <= fifo_dout;
                  timer   <= T_FIN;
                  Tx      <= 1'b0;
                  estado  <= INICIO;
               end
            end
            INICIO: begin
               if (timer == '0) begin
                  timer   <= T_FIN;
                  bit_idx <= '0;
                  Tx      <= desplaz[0];
                  estado  <= DATOS;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            DATOS: begin
               if (timer == '0) begin
                  timer <= T_FIN;
                  if (bit_idx == 3'd7) begin
                     Tx     <= 1'b1;
                     estado <= PARADA;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     desplaz <= {1'b0, desplaz[7:1]};
                     Tx      <= desplaz[1];
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            PARADA: begin
               if (timer == '0) begin
                  if (!vacio) begin
                     desplaz <= fifo_dout;
                     timer   <= T_FIN;
                     Tx      <= 1'b0;
                     estado  <= INICIO;
                  end else begin
                     Tx     <= 1'b1;
                     estado <= REPOSO;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            default: begin
               Tx     <= 1'b1;
               estado <= REPOSO;
            end
         endcase
      end
   end

endmodule
